// File: rtl/argmax_stream_if.sv
// Score-stream and result handshake bundle for argmax_stream.
// max_score is present only when ARGMAX_SCORE_OUT_EN is defined.
interface argmax_stream_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [IDX_W-1:0]  argmax_output;
   logic              frame_err;
`ifdef ARGMAX_SCORE_OUT_EN
   logic [DATA_W-1:0] max_score;
`endif

   // Upstream score source / downstream result sink
   modport master (
      output in_valid, in_data, in_last, out_ready,
`ifdef ARGMAX_SCORE_OUT_EN
      input  max_score,
`endif
      input  in_ready, out_valid, argmax_output, frame_err
   );

   // The argmax block itself
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
`ifdef ARGMAX_SCORE_OUT_EN
      output max_score,
`endif
      output in_ready, out_valid, argmax_output, frame_err
   );
endinterface

// File: rtl/argmax_stream.sv
// Streaming argmax over one frame of signed class scores with frame-length checking.
// Optional ARGMAX_SCORE_OUT_EN exposes the winning score on max_score.
module argmax_stream #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned NUM_CLASSES = 10,
   parameter int unsigned IDX_W       = 4
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           start,
   argmax_stream_if.slave bus
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                    state;
   logic [IDX_W-1:0]          count;
   logic [IDX_W-1:0]          best_idx;
   logic signed [DATA_W-1:0]  best;
   logic                      err_acc;
   logic                      in_ready_q;
   logic                      out_valid_q;
   logic [IDX_W-1:0]          argmax_q;
   logic                      frame_err_q;
`ifdef ARGMAX_SCORE_OUT_EN
   logic [DATA_W-1:0]         max_score_q;
`endif

   logic                      accept_c;
   logic                      better_c;
   logic                      at_last_c;
   logic                      frame_end_c;
   logic                      err_next_c;
   logic [IDX_W-1:0]          idx_next_c;
   logic signed [DATA_W-1:0]  best_next_c;

   assign bus.in_ready      = in_ready_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.argmax_output = argmax_q;
   assign bus.frame_err     = frame_err_q;
`ifdef ARGMAX_SCORE_OUT_EN
   assign bus.max_score     = max_score_q;
`endif

   // Running-max update for the beat on the bus; a start in the same cycle wins.
   always_comb begin
      accept_c    = (state == SCAN) && bus.in_valid && in_ready_q && !start;
      better_c    = (count == '0) || ($signed(bus.in_data) > best);
      idx_next_c  = better_c ? count : best_idx;
      best_next_c = better_c ? $signed(bus.in_data) : best;
      at_last_c   = (count == LAST_IDX);
      frame_end_c = bus.in_last || at_last_c;
      err_next_c  = err_acc | (bus.in_last ^ at_last_c);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         count       <= '0;
         best_idx    <= '0;
         best        <= '0;
         err_acc     <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         argmax_q    <= '0;
         frame_err_q <= 1'b0;
`ifdef ARGMAX_SCORE_OUT_EN
         max_score_q <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SCAN;
                  in_ready_q <= 1'b1;
                  count      <= '0;
                  best_idx   <= '0;
                  best       <= '0;
                  err_acc    <= 1'b0;
               end
            end
            SCAN: begin
               if (start) begin
                  count    <= '0;
                  best_idx <= '0;
                  best     <= '0;
                  err_acc  <= 1'b0;
               end else if (accept_c) begin
                  count <= count + IDX_W'(1);
                  if (frame_end_c) begin
                     state       <= DONE;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     argmax_q    <= idx_next_c;
                     frame_err_q <= err_next_c;
`ifdef ARGMAX_SCORE_OUT_EN
                     max_score_q <= best_next_c;
`endif
                  end
                  best     <= best_next_c;
                  best_idx <= idx_next_c;
                  err_acc  <= err_next_c;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_argmax_stream.sv
// Self-checking bench for argmax_stream: vector table plus restart, stall and reset sequences.
module tb_argmax_stream;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned NUM    = 10;
   localparam int unsigned IDX_W  = 4;

   typedef logic [DATA_W-1:0] scores_t [NUM];
   typedef struct {
      scores_t          s;
      int               last_at;
      bit               toggle;
      logic [IDX_W-1:0] idx;
      logic             err;
      logic [DATA_W-1:0] mx;
   } vec_t;
   typedef struct {
      logic [IDX_W-1:0]  idx;
      logic              err;
      logic [DATA_W-1:0] mx;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic start = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   vec_t tbl[6];

   always #5 clk = ~clk;

   argmax_stream_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

   argmax_stream #(.DATA_W(DATA_W), .NUM_CLASSES(NUM), .IDX_W(IDX_W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .bus    (bus.slave)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_in_ready"}, 64'(bus.in_ready), 0);
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 0);
      chk({tag, "_argmax"}, 64'(bus.argmax_output), 0);
      chk({tag, "_frame_err"}, 64'(bus.frame_err), 0);
`ifdef ARGMAX_SCORE_OUT_EN
      chk({tag, "_max_score"}, 64'(bus.max_score), 0);
`endif
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [DATA_W-1:0] d, input logic last, input bit gap);
      if (gap) begin
         bus.in_valid = 1'b0;
         @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      for (int t = 0; t < 50 && !bus.in_ready; t++) @(negedge clk);
      chk("beat_ready", 64'(bus.in_ready), 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send_frame(input scores_t s, input int last_at, input bit toggle);
      int nb;
      nb = (last_at >= 0 && last_at < int'(NUM) - 1) ? last_at + 1 : int'(NUM);
      pulse_start();
      for (int i = 0; i < nb; i++) send_beat(s[i], logic'(i == last_at), toggle);
   endtask

   // Wait for a result, optionally stall it for `hold` cycles, then consume it.
   task automatic wait_result(input int hold);
      exp_t e;
      bus.out_ready = (hold == 0);
      for (int t = 0; t < 100 && !bus.out_valid; t++) @(negedge clk);
      chk("out_valid_rise", 64'(bus.out_valid), 1);
      if (sb.size() > 0) e = sb.pop_front();
      else begin
         e = '{default: '0};
         checks++;
         errors++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end
      chk("argmax", 64'(bus.argmax_output), 64'(e.idx));
      chk("frame_err", 64'(bus.frame_err), 64'(e.err));
`ifdef ARGMAX_SCORE_OUT_EN
      chk("max_score", 64'(bus.max_score), 64'(e.mx));
`endif
      chk("done_in_ready", 64'(bus.in_ready), 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_out_valid", 64'(bus.out_valid), 1);
         chk("hold_argmax", 64'(bus.argmax_output), 64'(e.idx));
         chk("hold_frame_err", 64'(bus.frame_err), 64'(e.err));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("out_valid_fall", 64'(bus.out_valid), 0);
      chk("idle_argmax_held", 64'(bus.argmax_output), 64'(e.idx));
   endtask

   task automatic push_exp(input logic [IDX_W-1:0] idx, input logic err, input logic [DATA_W-1:0] mx);
      exp_t e;
      e.idx = idx;
      e.err = err;
      e.mx  = mx;
      sb.push_back(e);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      scores_t s;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;

      tbl[0].s = '{32'(3), 32'(-5), 32'(7), 32'(2), 32'(9), 32'(1), 32'(0), 32'(-8), 32'(4), 32'(6)};
      tbl[0].last_at = 9; tbl[0].toggle = 0; tbl[0].idx = 4; tbl[0].err = 0; tbl[0].mx = 32'(9);
      for (int i = 0; i < int'(NUM); i++) tbl[1].s[i] = 32'(-200);
      tbl[1].s[0] = 32'(-100);
      tbl[1].s[7] = 32'(-100);
      tbl[1].last_at = 9; tbl[1].toggle = 0; tbl[1].idx = 0; tbl[1].err = 0; tbl[1].mx = 32'(-100);
      for (int i = 0; i < int'(NUM); i++) tbl[2].s[i] = 32'(i * 1000 - 3000);
      tbl[2].s[9] = 32'h7FFF_FFFF;
      tbl[2].last_at = 9; tbl[2].toggle = 1; tbl[2].idx = 9; tbl[2].err = 0; tbl[2].mx = 32'h7FFF_FFFF;
      tbl[3].s = '{32'(1), 32'(2), 32'(10), 32'(3), 32'(4), 32'(5), 32'(20), 32'(30), 32'(99), 32'(0)};
      tbl[3].last_at = 5; tbl[3].toggle = 0; tbl[3].idx = 2; tbl[3].err = 1; tbl[3].mx = 32'(10);
      tbl[4].s = '{32'(0), 32'(1), 32'(2), 32'(3), 32'(4), 32'(5), 32'(6), 32'(7), 32'(8), 32'(-1)};
      tbl[4].last_at = -1; tbl[4].toggle = 0; tbl[4].idx = 8; tbl[4].err = 1; tbl[4].mx = 32'(8);
      for (int i = 0; i < int'(NUM); i++) tbl[5].s[i] = 32'h8000_0000;
      tbl[5].s[3] = 32'hFFFF_FFFF;
      tbl[5].s[6] = 32'hFFFF_FFFF;
      tbl[5].last_at = 9; tbl[5].toggle = 0; tbl[5].idx = 3; tbl[5].err = 0; tbl[5].mx = 32'hFFFF_FFFF;

      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      resetn = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", 64'(bus.in_ready), 0);

      foreach (tbl[k]) begin
         push_exp(tbl[k].idx, tbl[k].err, tbl[k].mx);
         send_frame(tbl[k].s, tbl[k].last_at, tbl[k].toggle);
         wait_result(0);
      end

      // Restart after 4 beats; a beat coincident with start must be dropped.
      pulse_start();
      for (int i = 0; i < 4; i++) send_beat(32'(1000 + i), 1'b0, 1'b0);
      start = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(5000);
      @(negedge clk);
      start = 1'b0;
      bus.in_valid = 1'b0;
      s = '{32'(10), 32'(20), 32'(300), 32'(40), 32'(50), 32'(60), 32'(70), 32'(80), 32'(90), 32'(100)};
      push_exp(4'd2, 1'b0, 32'(300));
      for (int i = 0; i < int'(NUM); i++) send_beat(s[i], logic'(i == 9), 1'b0);
      wait_result(5);

      // Reset while a result waits in DONE: result is lost.
      bus.out_ready = 1'b0;
      send_frame(tbl[3].s, tbl[3].last_at, 1'b0);
      for (int t = 0; t < 20 && !bus.out_valid; t++) @(negedge clk);
      chk("pre_reset_done", 64'(bus.out_valid), 1);
      resetn = 1'b0;
      #1;
      chk_zero_outputs("rst_done");
      @(negedge clk);
      resetn = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);

      // Reset mid-SCAN after a non-zero held result.
      push_exp(tbl[0].idx, tbl[0].err, tbl[0].mx);
      send_frame(tbl[0].s, tbl[0].last_at, 1'b0);
      wait_result(0);
      pulse_start();
      for (int i = 0; i < 3; i++) send_beat(32'(50 + i), 1'b0, 1'b0);
      resetn = 1'b0;
      #1;
      chk_zero_outputs("rst_scan");
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      push_exp(tbl[5].idx, tbl[5].err, tbl[5].mx);
      send_frame(tbl[5].s, tbl[5].last_at, 1'b0);
      wait_result(0);

      chk("scoreboard_drained", 64'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
